// File: rtl/exp_seq.sv
`default_nettype none
// ============================================================================
// Module   : exp_seq
// Brief    : Buffers up to DEPTH float32 values, feeds each through the
//            exponent unit's X/enb/Y/ack handshake, and writes the result
//            back in place for random-access readout.
//            Optional: EXP_SEQ_SAT_EN clamps exponent inputs to +/-88.0.
// Revision : 1.0
// ============================================================================
module exp_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int ADDR_W     = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_W:0]       len,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] exp_x,
   output logic                  exp_enb,
   input  logic [DATA_WIDTH-1:0] exp_y,
   input  logic                  exp_ack,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_ARM  = 3'd2,
      S_RUN  = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] c_one   = (ADDR_W + 1)'(1);
`ifdef EXP_SEQ_SAT_EN
   localparam logic [30:0]     c_lim_mag = 31'h42B0_0000;
`endif

   state_t                state_q, state_d;
   logic [ADDR_W:0]       idx_q, idx_d;
   logic [ADDR_W:0]       n_q, n_d;
   logic [DATA_WIDTH-1:0] exp_x_q, exp_x_d;
   logic [DATA_WIDTH-1:0] buf_q [DEPTH];

   logic                  buf_we;
   logic [ADDR_W-1:0]     buf_waddr;
   logic [DATA_WIDTH-1:0] buf_wdata;
   logic [ADDR_W:0]       idx_inc;
   logic                  idx_last;

   // Sign-magnitude clamp: NaN is excluded explicitly, +/-inf clamps like any
   // other out-of-range magnitude.
   function automatic logic [DATA_WIDTH-1:0] sat_x(input logic [DATA_WIDTH-1:0] x);
`ifdef EXP_SEQ_SAT_EN
      logic is_nan;
      is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      if (!is_nan && (x[30:0] > c_lim_mag)) begin
         sat_x = {x[31], c_lim_mag};
      end else begin
         sat_x = x;
      end
`else
      sat_x = x;
`endif
   endfunction

   assign idx_inc  = idx_q + c_one;
   assign idx_last = (idx_q == (n_q - c_one));

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      n_d       = n_q;
      exp_x_d   = exp_x_q;
      buf_we    = 1'b0;
      buf_waddr = idx_q[ADDR_W-1:0];
      buf_wdata = in_data;

      case (state_q)
         S_IDLE: begin
            exp_x_d = '0;
            if (start) begin
               idx_d   = '0;
               n_d     = (len > c_depth) ? c_depth : len;
               state_d = (len == '0) ? S_FIN : S_LOAD;
            end
         end

         S_LOAD: begin
            if (in_valid) begin
               buf_we    = 1'b1;
               buf_wdata = in_data;
               if (idx_last) begin
                  idx_d   = '0;
                  state_d = S_ARM;
                  // With a single element, buf[0] is being written on this
                  // very edge, so forward the incoming word instead.
                  exp_x_d = sat_x((idx_q == '0) ? in_data : buf_q[0]);
               end else begin
                  idx_d = idx_inc;
               end
            end
         end

         S_ARM: begin
            state_d = S_RUN;
         end

         S_RUN: begin
            if (exp_ack) begin
               buf_we    = 1'b1;
               buf_wdata = exp_y;
               idx_d     = idx_inc;
               if (idx_last) begin
                  state_d = S_FIN;
                  exp_x_d = '0;
               end else begin
                  state_d = S_ARM;
                  exp_x_d = sat_x(buf_q[idx_inc[ADDR_W-1:0]]);
               end
            end
         end

         S_FIN: begin
            exp_x_d = '0;
            state_d = S_IDLE;
         end

         default: begin
            exp_x_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         n_q     <= '0;
         exp_x_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         n_q     <= n_d;
         exp_x_q <= exp_x_d;
      end
   end

   // Element storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_q[buf_waddr] <= buf_wdata;
      end
   end

   assign in_ready = (state_q == S_LOAD);
   assign exp_enb  = (state_q == S_RUN);
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_FIN);
   assign exp_x    = exp_x_q;
   assign rd_data  = buf_q[rd_addr];

endmodule
`default_nettype wire
